// File: rtl/breath_led_ctrl.sv
// breath_led_ctrl: PWM LED driver with OFF / ON / BREATHE / BLINK modes.
// A divider produces PWM ticks; a frame is PWM_MAX+1 ticks. Commands are
// buffered in a one-deep pending slot and applied only at a frame boundary.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_mode/cmd_param/cmd_count  command payload
//   led                        PWM output (combinational from registered state)
//   duty                       current duty, 0..PWM_MAX+1
//   busy                       high whenever the mode is not OFF
//   done                       one-cycle pulse at end of a finite sequence
module breath_led_ctrl #(
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned PWM_MAX  = 999,
  parameter int unsigned DW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_mode,
  input  logic [7:0]    cmd_param,
  input  logic [7:0]    cmd_count,
  output logic          led,
  output logic [DW-1:0] duty,
  output logic          busy,
  output logic          done
);

  localparam int unsigned DVW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW  = (PWM_MAX > 0) ? $clog2(PWM_MAX + 1) : 1;
  localparam int unsigned CW  = (PW > DW) ? PW : DW;
  localparam int unsigned SW  = DW + 9;
  localparam logic [DW-1:0] FULL = DW'(PWM_MAX + 1);

  localparam logic [1:0] M_OFF     = 2'd0;
  localparam logic [1:0] M_ON      = 2'd1;
  localparam logic [1:0] M_BREATHE = 2'd2;
  localparam logic [1:0] M_BLINK   = 2'd3;

  typedef enum logic [2:0] {
    S_OFF, S_ON, S_UP, S_DOWN, S_BLK_ON, S_BLK_OFF
  } state_t;

  state_t           state;
  logic [DVW-1:0]   div_cnt;
  logic [PW-1:0]    pos;
  logic [1:0]       pend_mode;
  logic [7:0]       pend_param;
  logic [7:0]       pend_count;
  logic [7:0]       act_param;
  logic [7:0]       act_count;
  logic [7:0]       rep_cnt;
  logic [7:0]       frm_cnt;

  logic             tick;
  logic             frame_end;
  logic             seq_last;
  logic             blk_flip;
  logic [SW-1:0]    up_sum;

  // Frame timing and sequence helpers
  assign tick      = (div_cnt == DVW'(TICK_DIV - 1));
  assign frame_end = tick && (pos == PW'(PWM_MAX));
  assign up_sum    = SW'(duty) + SW'(act_param);
  // The completion about to happen is the last one of a finite sequence
  assign seq_last  = (act_count != 8'd0) && ((rep_cnt + 8'd1) == act_count);
  assign blk_flip  = ((frm_cnt + 8'd1) == act_param);

  // PWM comparator; duty PWM_MAX+1 exceeds every position so stays lit
  assign led = (CW'(pos) < CW'(duty));

  // Divider, frame position, command slot and mode sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OFF;
      div_cnt    <= '0;
      pos        <= '0;
      duty       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cmd_ready  <= 1'b1;
      pend_mode  <= M_OFF;
      pend_param <= 8'd1;
      pend_count <= 8'd0;
      act_param  <= 8'd1;
      act_count  <= 8'd0;
      rep_cnt    <= 8'd0;
      frm_cnt    <= 8'd0;
    end else begin
      done    <= 1'b0;
      div_cnt <= tick ? '0 : div_cnt + DVW'(1);
      if (tick) begin
        pos <= (pos == PW'(PWM_MAX)) ? '0 : pos + PW'(1);
      end

      // cmd_ready low doubles as the pending flag
      if (cmd_valid && cmd_ready) begin
        pend_mode  <= cmd_mode;
        pend_param <= (cmd_param == 8'd0) ? 8'd1 : cmd_param;
        pend_count <= cmd_count;
        cmd_ready  <= 1'b0;
      end

      if (frame_end) begin
        if (!cmd_ready) begin
          // A pending command overrides any completion on this boundary
          act_param <= pend_param;
          act_count <= pend_count;
          rep_cnt   <= 8'd0;
          frm_cnt   <= 8'd0;
          cmd_ready <= 1'b1;
          case (pend_mode)
            M_OFF:     begin state <= S_OFF;    duty <= '0;   busy <= 1'b0; end
            M_ON:      begin state <= S_ON;     duty <= FULL; busy <= 1'b1; end
            M_BREATHE: begin state <= S_UP;     duty <= '0;   busy <= 1'b1; end
            M_BLINK:   begin state <= S_BLK_ON; duty <= FULL; busy <= 1'b1; end
          endcase
        end else begin
          case (state)
            S_OFF, S_ON: ;
            S_UP: begin
              if (up_sum >= SW'(FULL)) begin
                duty  <= FULL;
                state <= S_DOWN;
              end else begin
                duty <= DW'(up_sum);
              end
            end
            S_DOWN: begin
              if (SW'(duty) <= SW'(act_param)) begin
                duty    <= '0;
                rep_cnt <= rep_cnt + 8'd1;
                if (seq_last) begin
                  state <= S_OFF;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state <= S_UP;
                end
              end else begin
                duty <= duty - DW'(act_param);
              end
            end
            S_BLK_ON: begin
              if (blk_flip) begin
                frm_cnt <= 8'd0;
                duty    <= '0;
                state   <= S_BLK_OFF;
              end else begin
                frm_cnt <= frm_cnt + 8'd1;
              end
            end
            S_BLK_OFF: begin
              if (blk_flip) begin
                frm_cnt <= 8'd0;
                rep_cnt <= rep_cnt + 8'd1;
                if (seq_last) begin
                  state <= S_OFF;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  duty  <= FULL;
                  state <= S_BLK_ON;
                end
              end else begin
                frm_cnt <= frm_cnt + 8'd1;
              end
            end
            default: begin
              state <= S_OFF;
              duty  <= '0;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_breath_led_ctrl.sv
// Scoreboard bench for breath_led_ctrl with TICK_DIV=2, PWM_MAX=3, DW=3
// (8 clk per frame). Stimulus pushes one expected entry per frame; the
// monitor pops at every frame boundary and checks duty/busy/cmd_ready, then
// at the following boundary checks led-high cycles and done pulses.
module tb_breath_led_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_param;
  logic [7:0] cmd_count;
  logic       led;
  logic [2:0] duty;
  logic       busy;
  logic       done;

  breath_led_ctrl #(.TICK_DIV(2), .PWM_MAX(3), .DW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_param (cmd_param),
    .cmd_count (cmd_count),
    .led       (led),
    .duty      (duty),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int duty;
    int busy;
    int done;
    int ready;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   active;
  int   led_cnt;
  int   done_cnt;
  int   cyc;
  int   checks;
  int   failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Posedges since reset release; frame boundaries fall on multiples of 8
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input int d, input int b, input int dn, input int r);
    exp_t e;
    e.duty = d; e.busy = b; e.done = dn; e.ready = r;
    q.push_back(e);
  endtask

  // Monitor: frame-boundary scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
    end else begin
      if (cyc != 0 && (cyc % 8) == 0) begin
        if (active) begin
          chk("led_high_cycles", led_cnt, 2 * cur.duty);
          chk("done_pulses", done_cnt, cur.done);
          active = 1'b0;
        end
        if (q.size() > 0) begin
          cur = q.pop_front();
          active = 1'b1;
          led_cnt = 0;
          done_cnt = 0;
          chk("frame_duty", int'(duty), cur.duty);
          chk("frame_busy", int'(busy), cur.busy);
          chk("frame_ready", int'(cmd_ready), cur.ready);
        end
      end
      if (active) begin
        led_cnt  += int'(led);
        done_cnt += int'(done);
      end
    end
  end

  task automatic align(input int r);
    do begin
      @(posedge clk);
      #2;
    end while ((cyc % 8) != r);
  endtask

  task automatic wait_q_empty();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("scoreboard_drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [7:0] p, input logic [7:0] c);
    align(2);
    cmd_mode  = m;
    cmd_param = p;
    cmd_count = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    chk("ready_after_accept", int'(cmd_ready), 0);
  endtask

  initial begin
    int n;
    int bre1[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    int bre3[8] = '{0, 3, 4, 1, 0, 3, 4, 1};
    int blk[8]  = '{4, 4, 0, 0, 4, 4, 0, 0};
    checks = 0;
    failures = 0;
    active = 1'b0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode = 2'd0;
    cmd_param = 8'd0;
    cmd_count = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", int'(led), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    #1;
    rst_n = 1'b1;

    // Idle after release
    push(0, 0, 0, 1);
    push(0, 0, 0, 1);
    wait_q_empty();

    // ON
    send(2'd1, 8'd0, 8'd0);
    push(4, 1, 0, 1);
    push(4, 1, 0, 1);
    wait_q_empty();

    // BREATHE step 1, one breath
    send(2'd2, 8'd1, 8'd1);
    foreach (bre1[i]) push(bre1[i], 1, 0, 1);
    push(0, 0, 1, 1);
    push(0, 0, 0, 1);
    wait_q_empty();

    // BREATHE step 3, forever, then OFF
    send(2'd2, 8'd3, 8'd0);
    foreach (bre3[i]) push(bre3[i], 1, 0, 1);
    wait_q_empty();
    send(2'd0, 8'd0, 8'd0);
    push(0, 0, 0, 1);
    wait_q_empty();

    // BLINK two frames per half, two pairs
    send(2'd3, 8'd2, 8'd2);
    foreach (blk[i]) push(blk[i], 1, 0, 1);
    push(0, 0, 1, 1);
    push(0, 0, 0, 1);
    wait_q_empty();

    // Second command held valid while the first is pending
    align(2);
    cmd_mode = 2'd2; cmd_param = 8'd1; cmd_count = 8'd0; cmd_valid = 1'b1;
    @(posedge clk);
    #2;
    cmd_mode = 2'd1;
    chk("hold_ready_first", int'(cmd_ready), 0);
    push(0, 1, 0, 1);
    align(7);
    chk("hold_ready_pending", int'(cmd_ready), 0);
    @(posedge clk);
    #2;
    chk("hold_ready_after_apply", int'(cmd_ready), 1);
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    chk("hold_ready_second", int'(cmd_ready), 0);
    push(4, 1, 0, 1);
    wait_q_empty();

    // Reset in the middle of a breath
    send(2'd2, 8'd1, 8'd0);
    push(0, 1, 0, 1);
    push(1, 1, 0, 1);
    wait_q_empty();
    align(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_led", int'(led), 0);
    chk("midrst_duty", int'(duty), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    push(0, 0, 0, 1);
    push(0, 0, 0, 1);
    wait_q_empty();

    n = 0;
    while (active && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (active) chk("final_frame_timeout", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
